basilisk_writeback_arbiter: RTL and testbench

//  Return path of the basilisk vector FPU: collects finished, already-rounded results from N functional-unit

---
 rtl/basilisk_writeback_arbiter_pkg.sv | 32 +++
 rtl/basilisk_rr_arbiter.sv | 66 ++++++
 rtl/basilisk_writeback_arbiter.sv | 99 +++++++++
 tb/tb_basilisk_writeback_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/basilisk_writeback_arbiter_pkg.sv
// Shared types and constants for the basilisk vector FPU writeback return path.
//   BASILISK_WRITEBACK_PORTS : default number of functional-unit result streams
//   basilisk_writeback_unit_t: port index of each functional unit
//   basilisk_writeback_result_t: one finished, already-rounded result (39 bits)
//   ptr_width()              : width of a round-robin pointer over n ports (>= 1)
package basilisk_writeback_arbiter_pkg;

  localparam int BASILISK_WRITEBACK_PORTS = 4;

  typedef enum logic [2:0] {
    ADD     = 3'd0,
    MULT    = 3'd1,
    DIVIDE  = 3'd2,
    SQRT    = 3'd3,
    CONVERT = 3'd4,
    MEMORY  = 3'd5
  } basilisk_writeback_unit_t;

  typedef struct packed {
    logic [4:0]  dest_reg_addr;
    logic [1:0]  dest_offset_addr;
    logic [31:0] result;
  } basilisk_writeback_result_t;

  localparam int BASILISK_RESULT_W = $bits(basilisk_writeback_result_t);

  // A single port still needs a 1-bit pointer so the vector is never zero-width.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/basilisk_rr_arbiter.sv
// Fair round-robin arbiter for the writeback return path.
//   clk, rst     : clock, synchronous active-high reset (clears the pointer)
//   i_req        : per-port request vector
//   i_enable     : grant may be issued (downstream has room, not in reset)
//   i_accept     : a granted request transferred on this edge
//   o_grant      : one-hot grant (all zero when disabled or no request)
//   o_grant_idx  : index of the selected port (meaningful when a grant is issued)
module basilisk_rr_arbiter
  import basilisk_writeback_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = BASILISK_WRITEBACK_PORTS,
  localparam int PTR_W    = ptr_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_enable,
  input  logic                 i_accept,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [PTR_W-1:0]     o_grant_idx
);

  logic [PTR_W-1:0] r_rr_ptr;
  logic             w_found;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_next_ptr;

  // Cyclic search from r_rr_ptr: first pass covers indices at or above the
  // pointer, second pass wraps around to the low indices.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && i_req[i] && (PTR_W'(i) >= r_rr_ptr)) begin
        w_found = 1'b1;
        w_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && i_req[i]) begin
        w_found = 1'b1;
        w_idx   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      o_grant[i] = i_enable && w_found && (w_idx == PTR_W'(i));
    end
  end

  assign o_grant_idx = w_idx;
  assign w_next_ptr  = (w_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : w_idx + PTR_W'(1);

  // Pointer moves past the winner only when the grant actually transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (i_accept) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/basilisk_writeback_arbiter.sv
// Merges N functional-unit result streams into one register-file writeback
// stream: round-robin arbitration into a 2-entry registered output buffer.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : per-port result valid
//   in_ready   : per-port result accepted (at most one bit high)
//   in_data    : packed results, port i at [39*i +: 39]
//   out_valid  : writeback valid (buffer not empty)
//   out_ready  : register file accepts the writeback
//   out_data   : head buffer entry {dest_reg_addr, dest_offset_addr, result}
//   busy       : buffer holds at least one entry
module basilisk_writeback_arbiter
  import basilisk_writeback_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = BASILISK_WRITEBACK_PORTS
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   in_valid,
  output logic [NUM_PORTS-1:0]                   in_ready,
  input  logic [NUM_PORTS*BASILISK_RESULT_W-1:0] in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [BASILISK_RESULT_W-1:0]           out_data,
  output logic                                   busy
);

  localparam int PTR_W = ptr_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]       w_grant;
  logic [PTR_W-1:0]           w_grant_idx;
  logic                       w_enable;
  logic                       w_push;
  logic                       w_pop;
  basilisk_writeback_result_t w_push_data;

  basilisk_writeback_result_t r_mem [2];
  logic                       r_wr_ptr;
  logic                       r_rd_ptr;
  logic [1:0]                 r_count;

  // Ready depends only on registered occupancy, never on out_ready, so a
  // full buffer refuses input even in the cycle it is being popped.
  assign w_enable = !rst && (r_count != 2'd2);

  basilisk_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .i_req       (in_valid),
    .i_enable    (w_enable),
    .i_accept    (w_push),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign in_ready = w_grant;
  assign w_push   = |(in_valid & w_grant);
  assign w_pop    = (r_count != 2'd0) && out_ready;

  always_comb begin
    w_push_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_grant_idx == PTR_W'(i)) begin
        w_push_data = in_data[i*BASILISK_RESULT_W +: BASILISK_RESULT_W];
      end
    end
  end

  // Output buffer: 1-bit pointers wrap naturally at two entries. The storage
  // is cleared on reset so out_data reads zero until the first result lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = (r_count != 2'd0);
  assign busy      = (r_count != 2'd0);

endmodule

// File: tb/tb_basilisk_writeback_arbiter.sv
module tb_basilisk_writeback_arbiter;
  import basilisk_writeback_arbiter_pkg::*;

  localparam int NP = 4;
  localparam int RW = 39;
  localparam logic [RW-1:0] R1 = 39'h15_3F80_0000;
  localparam logic [RW-1:0] R2 = 39'h15_4000_0000;
  localparam logic [RW-1:0] R3 = 39'h15_4040_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    in_valid, in_ready;
  logic [NP*RW-1:0] in_data;
  logic             out_valid, out_ready, busy;
  logic [RW-1:0]    out_data;

  logic [0:0]       v1, rdy1;
  logic [RW-1:0]    d1, od1;
  logic             ov1, or1, busy1;

  basilisk_writeback_arbiter #(.NUM_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  basilisk_writeback_arbiter #(.NUM_PORTS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int p, input int s);
    return {5'(p * 8 + s), 2'(s), 32'hA000_0000 | 32'(p << 8) | 32'(s)};
  endfunction

  // Unit-side sources: each port offers the head of its queue until accepted.
  logic [RW-1:0] src [NP][$];
  logic [NP-1:0] en;
  logic [NP-1:0] act_xfer;

  // Reference model: buffer contents as a queue, round-robin pointer as an int.
  logic [RW-1:0] mq [$];
  int            mptr;
  logic [NP-1:0] exp_ready;
  bit            m_found;
  int            m_p;
  bit            chk_en;
  int            glog [$];
  logic [RW-1:0] olog [$];
  int            t3_exp [8] = '{1, 3, 1, 3, 3, 3, 3, 3};

  initial begin
    in_valid = '0;
    in_data  = '0;
    act_xfer = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int p = 0; p < NP; p++)
        if (act_xfer[p] && src[p].size() > 0) void'(src[p].pop_front());
      for (int p = 0; p < NP; p++) begin
        in_valid[p]          = en[p] && (src[p].size() > 0);
        in_data[p*RW +: RW]  = (src[p].size() > 0) ? src[p][0] : '0;
      end
    end
  end

  always @(negedge clk) begin
    exp_ready = '0;
    m_found   = 1'b0;
    if (!rst && mq.size() < 2) begin
      for (int k = 0; k < NP; k++) begin
        m_p = (mptr + k) % NP;
        if (!m_found && in_valid[m_p]) begin
          exp_ready[m_p] = 1'b1;
          m_found        = 1'b1;
        end
      end
    end
    act_xfer = in_valid & in_ready;
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(exp_ready));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("busy", 64'(busy), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", 64'(out_data), 64'(mq[0]));
    end
    for (int p = 0; p < NP; p++) if (act_xfer[p]) glog.push_back(p);
    if (out_valid && out_ready) olog.push_back(out_data);
  end

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mptr = 0;
    end else begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      for (int p = 0; p < NP; p++)
        if (exp_ready[p] && in_valid[p]) begin
          mq.push_back(in_data[p*RW +: RW]);
          mptr = (p + 1) % NP;
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    for (int p = 0; p < NP; p++) src[p].delete();
    en = '0;
  endtask

  task automatic do_reset();
    clear_src();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; en = '0; chk_en = 1'b0;
    v1 = 1'b0; d1 = '0; or1 = 1'b0;
    src[0].push_back(mk(0, 7));
    en = 4'b0001;
    tick(); tick();
    chk_en = 1'b1;
    #6;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    clear_src();
    tick();
    rst = 1'b0;

    // Single port, three back-to-back results.
    out_ready = 1'b1;
    src[0].push_back(R1); src[0].push_back(R2); src[0].push_back(R3);
    en = 4'b0001;
    #6; chk("t1_c0_valid", 64'(out_valid), 64'd0);
    tick(); #6;
    chk("t1_c1_valid", 64'(out_valid), 64'd1);
    chk("t1_c1_data", 64'(out_data), 64'(R1));
    tick(); #6; chk("t1_c2_data", 64'(out_data), 64'(R2));
    tick(); #6; chk("t1_c3_data", 64'(out_data), 64'(R3));
    chk("t1_c3_busy", 64'(busy), 64'd1);
    tick(); #6;
    chk("t1_c4_valid", 64'(out_valid), 64'd0);
    chk("t1_c4_busy", 64'(busy), 64'd0);
    tick();

    // All ports valid continuously.
    do_reset();
    glog.delete(); olog.delete();
    for (int p = 0; p < NP; p++) for (int s = 0; s < 3; s++) src[p].push_back(mk(p, s));
    en = '1; out_ready = 1'b1;
    repeat (12) tick();
    chk("t2_grants", 64'(glog.size()), 64'd12);
    for (int i = 0; i < 12; i++) chk($sformatf("t2_grant%0d", i), 64'(glog[i]), 64'(i % 4));
    tick();
    chk("t2_outs", 64'(olog.size()), 64'd12);
    for (int i = 0; i < 12; i++) chk($sformatf("t2_out%0d", i), 64'(olog[i]), 64'(mk(i % 4, i / 4)));

    // Ports 1 and 3 only; port 1 runs dry first.
    do_reset();
    glog.delete();
    src[1].push_back(mk(1, 0)); src[1].push_back(mk(1, 1));
    for (int s = 0; s < 6; s++) src[3].push_back(mk(3, s));
    en = 4'b1010; out_ready = 1'b1;
    repeat (8) tick();
    chk("t3_grants", 64'(glog.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t3_grant%0d", i), 64'(glog[i]), 64'(t3_exp[i]));
    repeat (2) tick();

    // Backpressure: exactly two accepts, then drain in order.
    do_reset();
    glog.delete(); olog.delete();
    out_ready = 1'b0;
    for (int p = 0; p < NP; p++) for (int s = 0; s < 3; s++) src[p].push_back(mk(p, s));
    en = '1;
    repeat (5) tick();
    chk("t4_accepts", 64'(glog.size()), 64'd2);
    chk("t4_g0", 64'(glog[0]), 64'd0);
    chk("t4_g1", 64'(glog[1]), 64'd1);
    #6;
    chk("t4_full_ready", 64'(in_ready), 64'd0);
    chk("t4_hold_data", 64'(out_data), 64'(mk(0, 0)));
    tick();
    out_ready = 1'b1;
    #6; chk("t4_ready_at_pop", 64'(in_ready), 64'd0);
    tick(); #6; chk("t4_resume", 64'(|in_ready), 64'd1);
    repeat (20) tick();
    chk("t4_outs", 64'(olog.size()), 64'd12);
    for (int i = 0; i < 12; i++) chk($sformatf("t4_out%0d", i), 64'(olog[i]), 64'(mk(i % 4, i / 4)));

    // Reset while full; first grant afterwards goes to the lowest valid port.
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < NP; p++) for (int s = 0; s < 3; s++) src[p].push_back(mk(p, s));
    en = '1;
    repeat (4) tick();
    rst = 1'b1;
    #6;
    chk("t5_rst_ready", 64'(in_ready), 64'd0);
    chk("t5_pre_valid", 64'(out_valid), 64'd1);
    tick();
    rst = 1'b0;
    clear_src();
    for (int p = 1; p < NP; p++) src[p].push_back(mk(p, 4));
    en = 4'b1110; out_ready = 1'b1;
    #6;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_data", 64'(out_data), 64'd0);
    chk("t5_first_grant", 64'(in_ready), 64'b0010);
    repeat (6) tick();

    // Single-port build under backpressure.
    do_reset();
    v1 = 1'b1; d1 = mk(0, 1); or1 = 1'b0;
    #6;
    chk("t6_c0_ready", 64'(rdy1), 64'd1);
    chk("t6_c0_valid", 64'(ov1), 64'd0);
    chk("t6_c0_data", 64'(od1), 64'd0);
    tick(); d1 = mk(0, 2); #6;
    chk("t6_c1_ready", 64'(rdy1), 64'd1);
    chk("t6_c1_valid", 64'(ov1), 64'd1);
    chk("t6_c1_data", 64'(od1), 64'(mk(0, 1)));
    tick(); d1 = mk(0, 3); #6;
    chk("t6_c2_ready", 64'(rdy1), 64'd0);
    chk("t6_c2_data", 64'(od1), 64'(mk(0, 1)));
    chk("t6_c2_busy", 64'(busy1), 64'd1);
    tick(); #6;
    chk("t6_c3_ready", 64'(rdy1), 64'd0);
    chk("t6_c3_data", 64'(od1), 64'(mk(0, 1)));
    tick(); or1 = 1'b1; #6;
    chk("t6_c4_ready", 64'(rdy1), 64'd0);
    tick(); #6;
    chk("t6_c5_data", 64'(od1), 64'(mk(0, 2)));
    chk("t6_c5_ready", 64'(rdy1), 64'd1);
    tick(); v1 = 1'b0; #6;
    chk("t6_c6_data", 64'(od1), 64'(mk(0, 3)));
    chk("t6_c6_valid", 64'(ov1), 64'd1);
    tick(); #6;
    chk("t6_c7_valid", 64'(ov1), 64'd0);
    chk("t6_c7_busy", 64'(busy1), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
